// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions for the RV32I core: opcodes, the canonical NOP and
// hazard controller state encoding.
package rv_pipe_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    HALT
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of hazard inputs and stage-register controls.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             i_id_vld;
  logic [31:0]      i_id_instr;
  logic             i_ex_is_load;
  logic             i_ex_rd_wren;
  logic [4:0]       i_ex_rd;
  logic             i_ex_br_taken;
  logic             i_lsu_req;
  logic             i_lsu_ack;
  logic             o_pc_en;
  logic             o_if_id_en;
  logic             o_if_id_bubble;
  logic             o_id_ex_en;
  logic             o_id_ex_bubble;
  logic             o_ex_mem_en;
  logic             o_mem_wb_en;
  logic             o_halted;
  logic             o_mem_err;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_flush_cnt;

  // Pipeline datapath side.
  modport master (
    output i_id_vld, i_id_instr, i_ex_is_load, i_ex_rd_wren, i_ex_rd, i_ex_br_taken,
           i_lsu_req, i_lsu_ack,
    input  o_pc_en, o_if_id_en, o_if_id_bubble, o_id_ex_en, o_id_ex_bubble, o_ex_mem_en,
           o_mem_wb_en, o_halted, o_mem_err, o_stall_cnt, o_flush_cnt
  );

  // Hazard controller side.
  modport slave (
    input  i_id_vld, i_id_instr, i_ex_is_load, i_ex_rd_wren, i_ex_rd, i_ex_br_taken,
           i_lsu_req, i_lsu_ack,
    output o_pc_en, o_if_id_en, o_if_id_bubble, o_id_ex_en, o_id_ex_bubble, o_ex_mem_en,
           o_mem_wb_en, o_halted, o_mem_err, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/hz_lu_detect.sv
// Load-use hazard detector: decodes which source registers the ID instruction
// reads and matches them against a pending load destination in EX.
module hz_lu_detect
  import rv_pipe_pkg::*;
(
  input  logic        i_id_vld,
  input  logic [31:0] i_id_instr,
  input  logic        i_ex_is_load,
  input  logic        i_ex_rd_wren,
  input  logic [4:0]  i_ex_rd,
  output logic        o_lu_hazard
);

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       rs1_used;
  logic       rs2_used;
  logic       unused_instr;

  assign opcode       = i_id_instr[6:0];
  assign rs1          = i_id_instr[19:15];
  assign rs2          = i_id_instr[24:20];
  assign unused_instr = ^{i_id_instr[31:25], i_id_instr[14:7]};

  always_comb begin
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (opcode)
      LUI, AUIPC, JAL:   rs1_used = 1'b0;
      OP, STORE, BRANCH: rs2_used = 1'b1;
      default:           ;
    endcase
  end

  assign o_lu_hazard = i_id_vld & i_ex_is_load & i_ex_rd_wren & (i_ex_rd != 5'd0) &
                       ((rs1_used & (rs1 == i_ex_rd)) | (rs2_used & (rs2 == i_ex_rd)));

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline with a memory-wait watchdog.
// Stage controls are combinational; state and counters are registered.
module hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  hazard_ctrl_if.slave  hz
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  hz_state_e        state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             mem_err_q;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             freeze, lu_hazard, stall_inc, flush_inc;
  logic             pc_en, if_id_en, if_id_bubble, id_ex_en, id_ex_bubble, down_en;

  hz_lu_detect u_lu_detect (
    .i_id_vld     (hz.i_id_vld),
    .i_id_instr   (hz.i_id_instr),
    .i_ex_is_load (hz.i_ex_is_load),
    .i_ex_rd_wren (hz.i_ex_rd_wren),
    .i_ex_rd      (hz.i_ex_rd),
    .o_lu_hazard  (lu_hazard)
  );

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    freeze       = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_bubble = 1'b0;
    id_ex_en     = 1'b0;
    id_ex_bubble = 1'b0;
    down_en      = 1'b0;

    case (state_q)
      RUN: begin
        if (hz.i_lsu_req && !hz.i_lsu_ack) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = WaitW'(1);
        end
      end
      MEM_WAIT: begin
        // An ack in the timeout cycle still releases the pipeline.
        if (hz.i_lsu_ack) begin
          state_d = RUN;
          wait_d  = '0;
        end else begin
          freeze = 1'b1;
          if (wait_q == WaitW'(TIMEOUT)) begin
            state_d = HALT;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      HALT:    ;
      default: state_d = RUN;
    endcase

    if (!i_rst_n || state_q == HALT) begin
      // Everything held.
    end else if (freeze) begin
      stall_inc = 1'b1;
    end else if (hz.i_ex_br_taken) begin
      flush_inc    = 1'b1;
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      if_id_bubble = 1'b1;
      id_ex_en     = 1'b1;
      id_ex_bubble = 1'b1;
      down_en      = 1'b1;
    end else if (lu_hazard) begin
      stall_inc    = 1'b1;
      id_ex_en     = 1'b1;
      id_ex_bubble = 1'b1;
      down_en      = 1'b1;
    end else begin
      pc_en    = 1'b1;
      if_id_en = 1'b1;
      id_ex_en = 1'b1;
      down_en  = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= RUN;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= (state_d == HALT) && (state_q != HALT);
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign hz.o_pc_en        = pc_en;
  assign hz.o_if_id_en     = if_id_en;
  assign hz.o_if_id_bubble = if_id_bubble;
  assign hz.o_id_ex_en     = id_ex_en;
  assign hz.o_id_ex_bubble = id_ex_bubble;
  assign hz.o_ex_mem_en    = down_en;
  assign hz.o_mem_wb_en    = down_en;
  assign hz.o_halted       = (state_q == HALT);
  assign hz.o_mem_err      = mem_err_q;
  assign hz.o_stall_cnt    = stall_q;
  assign hz.o_flush_cnt    = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised bench for hazard_ctrl against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(32)) hif ();

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .hz      (hif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0 = running, 1 = waiting on memory, 2 = halted.
  int     m_mode  = 0;
  int     m_wait  = 0;
  longint m_stall = 0;
  longint m_flush = 0;
  bit     m_merr  = 0;
  localparam longint CntMax = 64'hFFFF_FFFF;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_load_use();
    int opc, s1, s2, rd;
    bit u1, u2;
    opc = int'(hif.i_id_instr) & 127;
    s1  = (int'(hif.i_id_instr) >> 15) & 31;
    s2  = (int'(hif.i_id_instr) >> 20) & 31;
    rd  = int'(hif.i_ex_rd);
    u1  = !(opc inside {55, 23, 111});   // lui, auipc, jal
    u2  = opc inside {51, 35, 99};       // op, store, branch
    if (!(hif.i_id_vld && hif.i_ex_is_load && hif.i_ex_rd_wren) || rd == 0) return 1'b0;
    return (u1 && s1 == rd) || (u2 && s2 == rd);
  endfunction

  // 0 hold, 1 memory freeze, 2 flush, 3 load-use stall, 4 normal.
  function automatic int m_action();
    if (!rst_n || m_mode == 2) return 0;
    if ((m_mode == 0 && hif.i_lsu_req && !hif.i_lsu_ack) || (m_mode == 1 && !hif.i_lsu_ack))
      return 1;
    if (hif.i_ex_br_taken) return 2;
    if (m_load_use()) return 3;
    return 4;
  endfunction

  // {pc, if_id_en, if_id_bubble, id_ex_en, id_ex_bubble, ex_mem, mem_wb}
  function automatic logic [6:0] m_ctl(input int a);
    case (a)
      2:       return 7'b111_1111;
      3:       return 7'b000_1111;
      4:       return 7'b110_1011;
      default: return 7'b000_0000;
    endcase
  endfunction

  task automatic model_clock();
    int a, nmode;
    a = m_action();
    if (!rst_n) begin
      m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_merr = 0;
      return;
    end
    nmode = m_mode;
    if (m_mode == 0 && hif.i_lsu_req && !hif.i_lsu_ack) begin
      nmode = 1; m_wait = 1;
    end else if (m_mode == 1) begin
      if (hif.i_lsu_ack) begin
        nmode = 0; m_wait = 0;
      end else if (m_wait == TO) begin
        nmode = 2;
      end else begin
        m_wait++;
      end
    end
    if ((a == 1 || a == 3) && m_stall < CntMax) m_stall++;
    if (a == 2 && m_flush < CntMax) m_flush++;
    m_merr = (nmode == 2) && (m_mode != 2);
    m_mode = nmode;
  endtask

  task automatic step(input bit rst, input bit vld, input logic [31:0] instr, input bit ld,
                      input bit wren, input logic [4:0] rd, input bit br, input bit req,
                      input bit ack);
    @(negedge clk);
    rst_n              = rst;
    hif.i_id_vld       = vld;
    hif.i_id_instr     = instr;
    hif.i_ex_is_load   = ld;
    hif.i_ex_rd_wren   = wren;
    hif.i_ex_rd        = rd;
    hif.i_ex_br_taken  = br;
    hif.i_lsu_req      = req;
    hif.i_lsu_ack      = ack;
    #1;
    check("ctl", {hif.o_pc_en, hif.o_if_id_en, hif.o_if_id_bubble, hif.o_id_ex_en,
                  hif.o_id_ex_bubble, hif.o_ex_mem_en, hif.o_mem_wb_en}, m_ctl(m_action()));
    check("halted", hif.o_halted, m_mode == 2);
    check("mem_err", hif.o_mem_err, m_merr);
    check("stall_cnt", hif.o_stall_cnt, m_stall);
    check("flush_cnt", hif.o_flush_cnt, m_flush);
    @(posedge clk);
    model_clock();
  endtask

  localparam logic [31:0] Nop    = 32'h0000_0013;
  localparam logic [31:0] AddX6  = {7'd0, 5'd1, 5'd5, 3'd0, 5'd6, 7'b0110011};
  localparam logic [31:0] LuiX5  = {12'd0, 5'd5, 3'd0, 5'd5, 7'b0110111};
  localparam logic [31:0] SwX5   = {7'd0, 5'd5, 5'd2, 3'b010, 5'd0, 7'b0100011};

  task automatic do_reset();
    step(0, 1, AddX6, 1, 1, 5'd5, 1, 1, 0);
    step(0, 0, Nop, 0, 0, 5'd0, 0, 0, 0);
  endtask

  task automatic idle(input bit req, input bit ack);
    step(1, 0, Nop, 0, 0, 5'd0, 0, req, ack);
  endtask

  initial begin
    logic [6:0] opcs [10];
    int halt_run;
    opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
    hif.i_id_vld = 0; hif.i_id_instr = Nop; hif.i_ex_is_load = 0; hif.i_ex_rd_wren = 0;
    hif.i_ex_rd = 0; hif.i_ex_br_taken = 0; hif.i_lsu_req = 0; hif.i_lsu_ack = 0;

    // Load-use stall lasts one cycle.
    do_reset();
    step(1, 1, AddX6, 1, 1, 5'd5, 0, 0, 0);
    #1 check("lu_stall_cnt", hif.o_stall_cnt, 1);
    step(1, 1, AddX6, 0, 1, 5'd5, 0, 0, 0);
    // No stall for rd=x0 or lui; sw reads rs2.
    step(1, 1, AddX6, 1, 1, 5'd0, 0, 0, 0);
    step(1, 1, LuiX5, 1, 1, 5'd5, 0, 0, 0);
    #1 check("lu_no_stall", hif.o_stall_cnt, 1);
    step(1, 1, SwX5, 1, 1, 5'd5, 0, 0, 0);
    #1 check("sw_stall", hif.o_stall_cnt, 2);

    // Flush beats a concurrent load-use hazard.
    do_reset();
    step(1, 1, AddX6, 1, 1, 5'd5, 1, 0, 0);
    #1 check("flush_cnt1", hif.o_flush_cnt, 1);
    check("flush_stall0", hif.o_stall_cnt, 0);

    // Three freeze cycles, released by ack in the fourth.
    do_reset();
    repeat (3) idle(1, 0);
    idle(1, 1);
    #1 check("wait3_stall", hif.o_stall_cnt, 3);
    check("wait3_run", hif.o_halted, 0);
    idle(0, 0);

    // Ack in the last permitted wait cycle avoids the halt.
    do_reset();
    repeat (TO) idle(1, 0);
    idle(1, 1);
    #1 check("ack_at_timeout", hif.o_halted, 0);

    // Watchdog: halt after TO wait cycles, then reset mid-halt.
    do_reset();
    repeat (TO + 1) idle(1, 0);
    #1 check("halt_entry", hif.o_halted, 1);
    check("mem_err_pulse", hif.o_mem_err, 1);
    idle(0, 1);
    #1 check("mem_err_once", hif.o_mem_err, 0);
    check("halt_sticky", hif.o_halted, 1);
    step(0, 0, Nop, 0, 0, 5'd0, 0, 0, 0);
    #1 check("halt_reset", hif.o_halted, 0);
    check("halt_reset_cnt", hif.o_stall_cnt, 0);

    // Reset mid-wait.
    repeat (2) idle(1, 0);
    step(0, 0, Nop, 0, 0, 5'd0, 0, 1, 0);
    idle(0, 0);

    // Randomised traffic; some phases starve the ack to reach the watchdog.
    halt_run = 0;
    for (int i = 0; i < 3000; i++) begin
      int seg;
      bit r, ack;
      logic [31:0] ins;
      seg = i / 500;
      ins = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             3'($urandom), 5'($urandom), opcs[$urandom_range(0, 9)]};
      ack = (seg == 2 || seg == 4) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      halt_run = (m_mode == 2) ? halt_run + 1 : 0;
      r = !(($urandom_range(0, 99) < 2) || halt_run > 6);
      step(r, 1'($urandom), ins, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
           5'($urandom_range(0, 7)), $urandom_range(0, 5) == 0,
           $urandom_range(0, 2) == 0, ack);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RV32I core. It produces the enable and bubble controls that the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC register consume. It detects load-use hazards, flushes on taken branches and jumps, and freezes the whole pipeline while the LSU waits on memory. A watchdog halts the core if a memory access never completes.

## Interface
- TIMEOUT, 64: maximum consecutive wait cycles in MEM_WAIT before the core halts.
- CNT_W, 32: width of the performance counters.
- i_clk  in  1  core clock.
- i_rst_n  in  1  reset; synchronous, active-low; clock i_clk.
- i_id_vld  in  1  ID stage holds a valid instruction.
- i_id_instr  in  32  instruction in ID.
- i_ex_is_load  in  1  EX holds a load (ld_en non-zero).
- i_ex_rd_wren  in  1  EX instruction writes rd.
- i_ex_rd  in  5  EX destination register.
- i_ex_br_taken  in  1  EX resolved a taken branch, JAL or JALR (PC redirect this cycle).
- i_lsu_req  in  1  MEM stage holds a valid load or store.
- i_lsu_ack  in  1  memory completes the MEM access this cycle.
- o_pc_en  out  1  PC register update enable.
- o_if_id_en  out  1  IF/ID enable.
- o_if_id_bubble  out  1  load NOP 0x00000013 with vld=0 into IF/ID.
- o_id_ex_en  out  1  ID/EX enable.
- o_id_ex_bubble  out  1  top-level mux forces insn_vld=0, rd_wren=0, lsu_wren=0, instr=NOP into ID/EX.
- o_ex_mem_en, o_mem_wb_en  out  1 each  downstream register enables.
- o_halted  out  1  core is frozen after a watchdog timeout.
- o_mem_err  out  1  one-cycle pulse on entry to HALT.
- o_stall_cnt, o_flush_cnt  out  CNT_W each  saturating performance counters.

## Operation
- FSM states are RUN, MEM_WAIT and HALT. Reset state is RUN.
- Priority order is HALT, then memory freeze, then branch flush, then load-use stall, then normal.
- **HALT / memory freeze:** all `*_en` = 0 and all bubbles = 0.
- **Branch flush** (i_ex_br_taken=1 and no freeze):
  - all enables = 1;
  - o_if_id_bubble = 1 and o_id_ex_bubble = 1;
  - o_flush_cnt increments by 1.
- **Load-use stall.** The hazard condition is i_id_vld & i_ex_is_load & i_ex_rd_wren & i_ex_rd≠0, with i_ex_rd matching a used source register.
  - rs1 = instr[19:15]. It is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 = instr[24:20]. It is used only by OP (0110011), STORE (0100011) and BRANCH (1100011).
  - Response: o_pc_en = o_if_id_en = 0, o_id_ex_en = 1 with o_id_ex_bubble = 1, EX/MEM and MEM/WB enabled.
  - o_stall_cnt increments by 1.
- **Normal:** all enables = 1 and bubbles = 0.
- **Memory freeze:**
  - In RUN: i_lsu_req & !i_lsu_ack freezes this cycle; next state is MEM_WAIT and the wait counter loads 1.
  - In MEM_WAIT with !i_lsu_ack: freeze; the wait counter increments.
  - In MEM_WAIT with i_lsu_ack=1: release in the same cycle (evaluate branch, load-use and normal as usual); next state is RUN.
  - Every freeze cycle increments o_stall_cnt.
- **Watchdog:** in MEM_WAIT, if the wait counter equals TIMEOUT and !i_lsu_ack, the next state is HALT.
  - o_mem_err is high for the first HALT cycle only.
  - o_halted stays high until reset.
  - If i_lsu_ack arrives in that same cycle, ack wins and the core does not halt.
- A taken branch during a freeze is held in EX because EX/MEM is disabled. It is flushed on the release cycle.
- Counters saturate at all-ones.

## Timing
- All enable and bubble outputs are combinational from the current state and inputs. They take effect on the same clock edge; latency is 0.
- State, the wait counter, o_mem_err and the performance counters are registered.
- Reset (i_rst_n=0 at a clock edge), applied in any state including mid-MEM_WAIT:
  - state → RUN, wait counter → 0;
  - o_mem_err = 0, o_halted = 0;
  - counters = 0.
- While i_rst_n=0, all `*_en` = 0 and all bubbles = 0.
- A load-use stall lasts exactly 1 cycle, because the load advances to MEM.
- A back-to-back load followed by a dependent instruction, then a MEM wait, gives a stall of 1 plus the number of wait cycles.

## Structure
- Shared package `rv_pipe_pkg` holds:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - `NOP_INSN = 32'h00000013`;
  - `hz_state_e {RUN, MEM_WAIT, HALT}`.
- One natural sub-module: `hz_lu_detect`, the combinational rs1/rs2 usage decoder and load-use match.

## Test plan
- Load x5, then `add x6,x5,x1` in ID (i_ex_rd=5, load=1) → one cycle with o_pc_en=0, o_if_id_en=0, o_id_ex_bubble=1; o_stall_cnt=1; next cycle normal.
- Load with rd=x0, or ID `lui x5` while EX loads x5 → no stall. ID `sw x5,0(x2)` while EX loads x5 → stall (rs2 used).
- i_ex_br_taken=1 concurrent with a load-use hazard → flush wins: both bubbles=1, all enables=1, o_flush_cnt=1, o_stall_cnt=0.
- i_lsu_req=1 with ack after 3 cycles (ack in 4th) → enables 0 for 3 cycles, released in the ack cycle; o_stall_cnt=3; state back to RUN.
- TIMEOUT=4 with ack never asserted → HALT entered after 4 MEM_WAIT cycles; o_mem_err pulses 1 cycle; o_halted stays 1. Ack exactly in the 4th wait cycle → no halt.
- Reset asserted mid-MEM_WAIT and mid-HALT → next cycle state RUN, counters 0, o_halted=0; all enables 0 while reset is held.
